// File: rtl/diffuse_rand_gen.sv
// Random (r1, r2) operand pair source for shade_diffuse.
// Two xorshift32 generators feed a counted burst FSM with -1.0 rejection.
module diffuse_rand_gen #(
    parameter logic [31:0] SEED_R1 = 32'h1234_5678,
    parameter logic [31:0] SEED_R2 = 32'h9E37_79B9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_vld,
    input  logic [31:0] seed_r1,
    input  logic [31:0] seed_r2,
    input  logic        start,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        op_vld,
    output logic [15:0] r1,
    output logic [15:0] r2
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s1_nxt;
    logic [31:0] s2_nxt;
    logic [31:0] seed_sel1;
    logic [31:0] seed_sel2;
    logic [15:0] remaining;
    logic [15:0] rem_nxt;
    logic [15:0] r1_nxt;
    logic [15:0] r2_nxt;
    logic        op_vld_nxt;
    logic        done_nxt;
    logic        acc;
    logic        last;
    logic        go;

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [15:0] cand(input logic [31:0] x);
        return {{2{x[13]}}, x[13:0]};
    endfunction

    // A zero state would lock xorshift at zero forever, so fall back to the seed.
    assign seed_sel1 = (seed_r1 == 32'd0) ? SEED_R1 : seed_r1;
    assign seed_sel2 = (seed_r2 == 32'd0) ? SEED_R2 : seed_r2;

    assign acc  = (s1[13:0] != 14'h2000) && (s2[13:0] != 14'h2000);
    assign last = acc && (remaining == 16'd1);
    assign go   = start && (count != 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        busy       = (state == RUN);
        s1_nxt     = s1;
        s2_nxt     = s2;
        rem_nxt    = remaining;
        r1_nxt     = r1;
        r2_nxt     = r2;
        op_vld_nxt = 1'b0;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (seed_vld) begin
                    s1_nxt = seed_sel1;
                    s2_nxt = seed_sel2;
                end
                if (start) begin
                    rem_nxt  = count;
                    done_nxt = (count == 16'd0);
                end
            end
            RUN: begin
                s1_nxt = xs_step(s1);
                s2_nxt = xs_step(s2);
                if (acc) begin
                    op_vld_nxt = 1'b1;
                    r1_nxt     = cand(s1);
                    r2_nxt     = cand(s2);
                    rem_nxt    = remaining - 16'd1;
                    done_nxt   = last;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= SEED_R1;
            s2        <= SEED_R2;
            remaining <= 16'd0;
            op_vld    <= 1'b0;
            done      <= 1'b0;
            r1        <= 16'd0;
            r2        <= 16'd0;
        end else begin
            s1        <= s1_nxt;
            s2        <= s2_nxt;
            remaining <= rem_nxt;
            op_vld    <= op_vld_nxt;
            done      <= done_nxt;
            r1        <= r1_nxt;
            r2        <= r2_nxt;
        end
    end

endmodule

// File: tb/tb_diffuse_rand_gen.sv
// Scoreboard bench for diffuse_rand_gen.
// Reference xorshift model predicts every pair and its arrival cycle.
module tb_diffuse_rand_gen;

    localparam logic [31:0] SEED_R1 = 32'h1234_5678;
    localparam logic [31:0] SEED_R2 = 32'h9E37_79B9;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_vld;
    logic [31:0] seed_r1;
    logic [31:0] seed_r2;
    logic        start;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        op_vld;
    logic [15:0] r1;
    logic [15:0] r2;

    diffuse_rand_gen dut (
        .clk     (clk),
        .rst     (rst),
        .seed_vld(seed_vld),
        .seed_r1 (seed_r1),
        .seed_r2 (seed_r2),
        .start   (start),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .op_vld  (op_vld),
        .r1      (r1),
        .r2      (r2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        int          at;
        logic        last;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          npop = 0;
    logic [31:0] m1 = SEED_R1;
    logic [31:0] m2 = SEED_R2;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [15:0] sx(input logic [31:0] x);
        logic [13:0] v;
        v = x[13:0];
        return {{2{v[13]}}, v};
    endfunction

    task automatic load_model(input logic [31:0] a, input logic [31:0] b);
        m1 = (a == 32'd0) ? SEED_R1 : a;
        m2 = (b == 32'd0) ? SEED_R2 : b;
    endtask

    task automatic plan(input int n, input int base);
        exp_t e;
        int   t;
        bit   got;
        t = base + 2;
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            while (!got) begin
                if (m1[13:0] != 14'h2000 && m2[13:0] != 14'h2000) begin
                    e.r1   = sx(m1);
                    e.r2   = sx(m2);
                    e.at   = t;
                    e.last = (i == n - 1);
                    q.push_back(e);
                    got = 1'b1;
                end
                m1 = xs(m1);
                m2 = xs(m2);
                t++;
            end
        end
    endtask

    // One-cycle stimulus pulse issued while the DUT is idle; returns its cycle.
    task automatic kick(input logic sv, input logic [31:0] a,
                        input logic [31:0] b, input logic st,
                        input logic [15:0] n, output int k);
        @(negedge clk);
        k        = cyc;
        seed_vld = sv;
        seed_r1  = a;
        seed_r2  = b;
        start    = st;
        count    = n;
        if (sv) load_model(a, b);
        if (st && n != 16'd0) plan(int'(n), k);
        @(negedge clk);
        seed_vld = 1'b0;
        start    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (op_vld) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_op_vld cyc=%0d got r1=%h r2=%h want none",
                             cyc, r1, r2);
                end else begin
                    mon_e = q.pop_front();
                    npop++;
                    if (r1 !== mon_e.r1 || r2 !== mon_e.r2 || cyc != mon_e.at ||
                        done !== mon_e.last || busy !== !mon_e.last) begin
                        bad++;
                        $display("FAIL pair cyc=%0d got r1=%h r2=%h done=%b busy=%b want cyc=%0d r1=%h r2=%h done=%b busy=%b",
                                 cyc, r1, r2, done, busy, mon_e.at, mon_e.r1,
                                 mon_e.r2, mon_e.last, !mon_e.last);
                    end
                end
            end else if (q.size() != 0 && cyc >= q[0].at) begin
                total++;
                bad++;
                $display("FAIL missing_op_vld cyc=%0d got op_vld=0 want r1=%h r2=%h",
                         cyc, q[0].r1, q[0].r2);
                void'(q.pop_front());
            end
        end
    end

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({busy, done, op_vld, r1, r2} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b op_vld=%b r1=%h r2=%h want all 0",
                     busy, done, op_vld, r1, r2);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, op_vld, r1, r2} !== 35'd0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b op_vld=%b want 0",
                     busy, done, op_vld);
        end
    endtask

    task automatic test_basic;
        int k;
        kick(1'b1, 32'd1, 32'd1, 1'b0, 16'd0, k);
        kick(1'b0, 32'd0, 32'd0, 1'b1, 16'd2, k);
        total++;
        if (busy !== 1'b1 || op_vld !== 1'b0) begin
            bad++;
            $display("FAIL basic_run_cycle got busy=%b op_vld=%b want 1 0", busy, op_vld);
        end
        @(negedge clk);
        total++;
        if (op_vld !== 1'b1 || r1 !== 16'h0001 || r2 !== 16'h0001 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_pair0 got v=%b r1=%h r2=%h done=%b want 1 0001 0001 0",
                     op_vld, r1, r2, done);
        end
        @(negedge clk);
        total++;
        if (op_vld !== 1'b1 || r1 !== 16'hE021 || r2 !== 16'hE021 ||
            done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_pair1 got v=%b r1=%h r2=%h done=%b busy=%b want 1 e021 e021 1 0",
                     op_vld, r1, r2, done, busy);
        end
        @(negedge clk);
        total++;
        if (op_vld !== 1'b0 || done !== 1'b0 || r1 !== 16'hE021) begin
            bad++;
            $display("FAIL basic_hold got v=%b done=%b r1=%h want 0 0 e021", op_vld, done, r1);
        end
    endtask

    task automatic test_reject;
        int k;
        kick(1'b1, 32'h0000_2000, 32'd1, 1'b1, 16'd1, k);
        @(negedge clk);
        total++;
        if (op_vld !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reject_skip got v=%b busy=%b want 0 1", op_vld, busy);
        end
        @(negedge clk);
        total++;
        if (op_vld !== 1'b1 || r1 !== 16'hE200 || r2 !== 16'hE021 || done !== 1'b1) begin
            bad++;
            $display("FAIL reject_pair got v=%b r1=%h r2=%h done=%b want 1 e200 e021 1",
                     op_vld, r1, r2, done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_seed;
        int k;
        kick(1'b1, 32'd0, 32'd0, 1'b0, 16'd0, k);
        kick(1'b0, 32'd0, 32'd0, 1'b1, 16'd1, k);
        @(negedge clk);
        total++;
        if (op_vld !== 1'b1 || r1 !== 16'h1678 || r2 !== 16'hF9B9) begin
            bad++;
            $display("FAIL zero_seed got v=%b r1=%h r2=%h want 1 1678 f9b9", op_vld, r1, r2);
        end
        @(negedge clk);
    endtask

    task automatic test_count_zero;
        int k;
        kick(1'b0, 32'd0, 32'd0, 1'b1, 16'd0, k);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || op_vld !== 1'b0) begin
            bad++;
            $display("FAIL count0_done got done=%b busy=%b v=%b want 1 0 0", done, busy, op_vld);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || op_vld !== 1'b0) begin
                bad++;
                $display("FAIL count0_quiet got done=%b busy=%b v=%b want 0 0 0",
                         done, busy, op_vld);
            end
        end
    endtask

    task automatic test_ignore_in_run;
        int k;
        int n0;
        n0 = npop;
        kick(1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, 16'd4, k);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            seed_vld = 1'b1;
            seed_r1  = $urandom;
            seed_r2  = $urandom;
            start    = 1'b1;
            count    = 16'd7;
        end
        @(negedge clk);
        seed_vld = 1'b0;
        start    = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++;
        if (npop - n0 != 4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_in_run got pairs=%0d busy=%b want 4 0", npop - n0, busy);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int n0;
        n0 = npop;
        kick(1'b0, 32'd0, 32'd0, 1'b1, 16'd5, k);
        for (int i = 0; i < 40 && npop - n0 < 2; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (npop - n0 != 2) begin
            bad++;
            $display("FAIL mid_wait got pairs=%0d want 2", npop - n0);
        end
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        total++;
        if (op_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || r1 !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset got v=%b busy=%b done=%b r1=%h want 0 0 0 0",
                     op_vld, busy, done, r1);
        end
        rst = 1'b0;
        m1  = SEED_R1;
        m2  = SEED_R2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || op_vld !== 1'b0) begin
                bad++;
                $display("FAIL mid_no_done got done=%b v=%b want 0 0", done, op_vld);
            end
        end
        kick(1'b0, 32'd0, 32'd0, 1'b1, 16'd3, k);
        @(negedge clk);
        total++;
        if (op_vld !== 1'b1 || r1 !== 16'h1678 || r2 !== 16'hF9B9) begin
            bad++;
            $display("FAIL mid_restart got v=%b r1=%h r2=%h want 1 1678 f9b9", op_vld, r1, r2);
        end
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int k;
        int n0;
        n0 = npop;
        kick(1'b1, $urandom, $urandom, 1'b1, 16'd200, k);
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        kick(1'b0, 32'd0, 32'd0, 1'b1, 16'd50, k);
        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0 || npop - n0 != 250) begin
            bad++;
            $display("FAIL long_bursts got pairs=%0d pending=%0d want 250 0",
                     npop - n0, q.size());
            q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        seed_vld = 1'b0;
        seed_r1  = 32'd0;
        seed_r2  = 32'd0;
        start    = 1'b0;
        count    = 16'd0;
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_reject;
        test_zero_seed;
        test_count_zero;
        test_ignore_in_run;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/diffuse_rand_gen.md
Name: diffuse_rand_gen

Overview:
Produces the (r1, r2) random operand pairs consumed by shade_diffuse: 16-bit Q3.13 values strictly inside (-1.0, 1.0), each pair qualified by a one-cycle op_vld pulse. Two independent xorshift32 generators drive a counted burst FSM: software or the bounce controller requests N samples, and the block emits exactly N valid pairs. Candidates equal to -1.0 are rejected and resampled. The op_vld/r1/r2 outputs connect directly to shade_diffuse; there is no backpressure.

Parameters:
SEED_R1, 32'h1234_5678, reset seed of the r1 generator; also substituted whenever a zero seed is loaded.
SEED_R2, 32'h9E37_79B9, reset seed of the r2 generator; same zero-substitution rule.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
seed_vld  in  1  load seed_r1/seed_r2 into generator states (honoured in IDLE only)
seed_r1  in  32  new r1 generator state
seed_r2  in  32  new r2 generator state
start  in  1  begin a burst of count pairs (honoured in IDLE only)
count  in  16  number of pairs to emit, sampled with start
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
op_vld  out  1  r1/r2 valid this cycle
r1  out  16  Q3.13 sample, range [-8191, 8191] LSB
r2  out  16  Q3.13 sample, range [-8191, 8191] LSB

Behaviour:
- Reset: FSM=IDLE; s1=SEED_R1, s2=SEED_R2; remaining=0; busy=0, done=0, op_vld=0, r1=0, r2=0.
- Generator step (combinational, one step per cycle): x^=x<<13; x^=x>>17; x^=x<<5 (32-bit, logical shifts).
- Candidate from the current state, before stepping: c=sign-extend(s[13:0]) to 16 bits. A candidate is rejected iff s[13:0]==14'h2000 (-1.0).
- FSM states are IDLE and RUN.
- IDLE:
  - seed_vld: s1<=seed_r1, or SEED_R1 if seed_r1==0. s2 is loaded the same way.
  - start with count!=0: remaining<=count, go to RUN, busy=1 from the next cycle.
  - start with count==0: done pulses the next cycle, stay IDLE, no op_vld.
  - seed_vld and start in the same cycle: the seeds are loaded first. The burst uses the new seeds.
  - States do not step in IDLE.
- RUN, every cycle:
  - Both generators step.
  - If both candidates are accepted: next cycle op_vld=1, r1=c1, r2=c2, and remaining decrements.
  - If either is rejected: the whole pair is discarded, op_vld=0 next cycle, remaining is unchanged.
- Registered outputs: r1/r2 hold their last value when op_vld=0.
- Completion: when the accepted pair makes remaining reach 0, FSM returns to IDLE. done=1 and busy=0 in the same cycle as the final op_vld.
- Latency: first op_vld appears 2 cycles after start (start at t, RUN at t+1, output at t+2) when there are no rejections. Each rejection adds 1 cycle.
- In RUN, start and seed_vld are ignored.
- rst mid-burst: the burst is aborted; all state returns to reset values next cycle; no done pulse.
- remaining is 16 bits; count=16'hFFFF is legal and emits 65535 pairs.

Test Plan:
1. Seed pair (1, 1), start count=2 -> op_vld on cycles t+2 and t+3. Pairs are (0x0001, 0x0001) then (0xE021, 0xE021). done and busy fall at t+3.
2. Rejection: seeds (0x00002000, 0x00000001), count=1 -> cycle t+2 op_vld=0. Cycle t+3 op_vld=1 with r1=0xE200 (next state 0x84046200), r2=0xE021.
3. Zero seed: seed_vld with (0, 0), then count=1 -> output equals the first pair after reset (from SEED_R1/SEED_R2, e.g. r1=0x1678 sign-ext), never stuck at 0.
4. count=0 -> done pulses once, op_vld stays 0, busy stays 0.
5. start and seed_vld asserted during a count=4 burst -> ignored: exactly 4 op_vld pulses, sequence unchanged.
6. rst asserted after 2 of 5 pairs -> op_vld=0, busy=0, no done; next burst repeats the post-reset sequence.
